lap_bank_ctrl: RTL and testbench
================================

# lap_bank_ctrl

Controller for the stopwatch lap register bank. Captures the running time on a save command, stores it in a DEPTH-entry circular buffer, and returns stored laps one at a time on retrieve. It also sweeps the bank to zero on clear. It sits between control_fsm (SAVE, RETRIEVE, CLEAR states) and the display path, and drives the `reg_busy` stimulus back into control_fsm.

## Interface
Parameters:
- DEPTH, 8, number of lap entries; power of two, 2..64.
- EPOCH_W, 18, width of {hour, minute, second}, 6 bits each.
- MSEC_W, 10, width of the millisecond field.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- save  in  1  store the current time; sampled only in IDLE.
- retrieve  in  1  output the next stored lap; sampled only in IDLE.
- clear  in  1  erase all entries; sampled only in IDLE.
- epoch  in  EPOCH_W  live {hour, minute, second} from the stopwatch.
- m_epoch  in  MSEC_W  live millisecond value from the stopwatch.
- busy  out  1  high whenever state is not IDLE; feeds control_fsm `reg_busy`.
- rd_epoch  out  EPOCH_W  retrieved {hour, minute, second}.
- rd_m_epoch  out  MSEC_W  retrieved milliseconds.
- rd_index  out  $clog2(DEPTH)  lap number of the retrieved entry, 0 = oldest.
- rd_valid  out  1  one-cycle pulse when the rd_* outputs update.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  count == DEPTH.

## Operation
- **States:** IDLE, SAVE_WR, RD, CLR_SWEEP.
- **Reset values:** state = IDLE; wr_ptr = rd_ptr = count = 0; sweep counter = 0; all rd_* = 0; rd_valid = 0; busy = 0; full = 0; memory contents undefined.
- **Command priority in IDLE:** clear > save > retrieve. A lower-priority command asserted in the same cycle is dropped, not queued.
- **Commands while busy:** ignored.
- **save (IDLE):**
  - The snapshot register loads {epoch, m_epoch} on the same edge; state goes to SAVE_WR.
  - In SAVE_WR: mem[wr_ptr] <= snapshot; wr_ptr increments, wrapping DEPTH-1 -> 0; count increments; state goes to IDLE.
- **save when full:** behaviour is set by the macro (see Configuration).
- **retrieve, count > 0:**
  - The edge latches rd_ptr; state goes to RD.
  - In RD: rd_* load from mem[rd_ptr], and rd_index = (rd_ptr - oldest) mod DEPTH, where oldest = wr_ptr - count mod DEPTH.
  - rd_ptr advances. After the newest entry it wraps back to oldest, so repeated retrieves cycle through the laps in oldest-first order.
  - rd_valid = 1 in the following cycle; state goes to IDLE.
- **retrieve, count == 0:** state goes to RD for one cycle; rd_* keep their values; no rd_valid pulse.
- **clear:**
  - wr_ptr, rd_ptr, count and the rd_* outputs go to 0 on the accepting edge; state goes to CLR_SWEEP.
  - The sweep writes zero to mem[0..DEPTH-1], one entry per cycle, then returns to IDLE.
- **Arithmetic:** all pointer arithmetic is modulo DEPTH. count saturates at DEPTH and never goes below 0.
- **Asynchronous reset mid-operation:** aborts any save, retrieve or sweep immediately, with all outputs at their reset values. A partially written entry is never counted as valid.

## Timing
- busy is decoded combinationally from the registered state; no combinational path from inputs to busy.
- **save:** accepted at edge N; busy = 1 for cycle N..N+1; entry written and count updated at edge N+1; IDLE again from cycle N+1. The stored time is the value present at edge N.
- **retrieve:** accepted at edge N; RD during cycle N..N+1; rd_* and rd_valid valid from edge N+1 for one cycle. rd_* hold afterwards.
- **clear:** busy = 1 for exactly DEPTH cycles after the accepting edge.
- A new command is accepted at the first edge where state == IDLE.

## Configuration
- **`LAP_BANK_OVERWRITE_EN` defined:** save when full overwrites the oldest entry.
  - wr_ptr advances; count stays at DEPTH.
  - If rd_ptr pointed at the overwritten entry, it advances to the new oldest entry.
- **Not defined:** save when full is accepted but performs no write.
  - busy still pulses for one cycle; pointers and count are unchanged; full stays 1.

## Structure
- **Package lap_bank_pkg:** state enum (IDLE, SAVE_WR, RD, CLR_SWEEP), EPOCH_W/MSEC_W defaults, and the packed lap-entry typedef {epoch, m_epoch}.
- **Sub-module lap_bank_mem:** DEPTH x (EPOCH_W + MSEC_W) register array with one synchronous write port and a combinational read port. No reset on the array.
- **Top of the block:** the FSM, the pointers and the output registers.

## Test plan
- **Reset then save:** reset, then save with epoch = {1, 2, 3}, m_epoch = 456 → busy high for 1 cycle; count = 1; a following retrieve gives rd_epoch = {1, 2, 3}, rd_m_epoch = 456, rd_index = 0, rd_valid pulses once.
- **Save three, retrieve four:** save 3 distinct times, then retrieve 4 times → rd_index sequence 0, 1, 2, 0 with matching times.
- **Fill and overflow, DEPTH = 8:** 9 saves → full = 1. With the macro: retrieve sequence starts at lap 2's time and count = 8. Without the macro: retrieve sequence starts at lap 1's time and the 9th time is absent.
- **Simultaneous commands:** clear, save and retrieve together in IDLE → only the clear executes; busy = 8 cycles; count = 0; no write occurs.
- **Retrieve on empty bank:** → busy for 1 cycle, rd_valid stays 0, rd_* unchanged.
- **Reset during sweep:** assert reset at cycle 3 of CLR_SWEEP → busy = 0 and count = 0 immediately; a save after release is stored at index 0.

Source files
------------

// File: rtl/lap_bank_pkg.sv
// Lap register bank shared definitions: FSM states, default field widths,
// and the packed lap entry layout {epoch, m_epoch}.
package lap_bank_pkg;

  localparam int unsigned LAP_EPOCH_W = 18;  // {hour, minute, second}, 6 bits each
  localparam int unsigned LAP_MSEC_W  = 10;  // millisecond field

  typedef enum logic [1:0] {
    IDLE,
    SAVE_WR,
    RD,
    CLR_SWEEP
  } state_e;

  typedef struct packed {
    logic [LAP_EPOCH_W-1:0] epoch;
    logic [LAP_MSEC_W-1:0]  m_epoch;
  } lap_t;

endpackage

// File: rtl/lap_bank_mem.sv
// Lap storage array: DEPTH x WIDTH registers, one synchronous write port,
// one combinational read port. The array is intentionally not reset.
module lap_bank_mem
  import lap_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = $bits(lap_t)
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port, one entry per cycle
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_bank_ctrl.sv
// Lap bank controller: captures the running time on save, stores it in a
// circular buffer, returns laps oldest-first on retrieve, sweeps to zero on
// clear. Optional macro LAP_BANK_OVERWRITE_EN: save when full overwrites the
// oldest entry instead of being dropped.
module lap_bank_ctrl
  import lap_bank_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned EPOCH_W = LAP_EPOCH_W,
  parameter int unsigned MSEC_W  = LAP_MSEC_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       save,
  input  logic                       retrieve,
  input  logic                       clear,
  input  logic [EPOCH_W-1:0]         epoch,
  input  logic [MSEC_W-1:0]          m_epoch,
  output logic                       busy,
  output logic [EPOCH_W-1:0]         rd_epoch,
  output logic [MSEC_W-1:0]          rd_m_epoch,
  output logic [$clog2(DEPTH)-1:0]   rd_index,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned DW = EPOCH_W + MSEC_W;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     sweep_q, sweep_d;
  logic [DW-1:0]     snap_q, snap_d;
  logic [EPOCH_W-1:0] rd_epoch_q, rd_epoch_d;
  logic [MSEC_W-1:0] rd_m_epoch_q, rd_m_epoch_d;
  logic [AW-1:0]     rd_index_q, rd_index_d;
  logic              rd_valid_q, rd_valid_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic [AW-1:0]     oldest;
  logic [AW-1:0]     newest;
  logic              is_full;

  lap_bank_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Count of DEPTH truncates to 0 in AW bits, so a full bank gives oldest == wr_ptr.
  assign oldest  = wr_ptr_q - count_q[AW-1:0];
  assign newest  = wr_ptr_q - AW'(1);
  assign is_full = (count_q == CW'(DEPTH));

  // Next-state, pointer, memory-port and output-register logic
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    sweep_d      = sweep_q;
    snap_d       = snap_q;
    rd_epoch_d   = rd_epoch_q;
    rd_m_epoch_d = rd_m_epoch_q;
    rd_index_d   = rd_index_q;
    rd_valid_d   = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q;
    mem_wdata    = snap_q;

    case (state_q)
      IDLE: begin
        if (clear) begin
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          count_d      = '0;
          sweep_d      = '0;
          rd_epoch_d   = '0;
          rd_m_epoch_d = '0;
          rd_index_d   = '0;
          state_d      = CLR_SWEEP;
        end else if (save) begin
          snap_d  = {epoch, m_epoch};
          state_d = SAVE_WR;
        end else if (retrieve) begin
          state_d = RD;
        end
      end

      SAVE_WR: begin
        if (!is_full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end else begin
`ifdef LAP_BANK_OVERWRITE_EN
          // Full: wr_ptr is the oldest slot; a reader parked there moves to the new oldest.
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (rd_ptr_q == wr_ptr_q) rd_ptr_d = wr_ptr_q + AW'(1);
`endif
        end
        state_d = IDLE;
      end

      RD: begin
        if (count_q != '0) begin
          rd_epoch_d   = mem_rdata[DW-1:MSEC_W];
          rd_m_epoch_d = mem_rdata[MSEC_W-1:0];
          rd_index_d   = rd_ptr_q - oldest;
          rd_ptr_d     = (rd_ptr_q == newest) ? oldest : rd_ptr_q + AW'(1);
          rd_valid_d   = 1'b1;
        end
        state_d = IDLE;
      end

      CLR_SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + AW'(1);
        if (sweep_q == AW'(DEPTH - 1)) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sweep_q      <= '0;
      snap_q       <= '0;
      rd_epoch_q   <= '0;
      rd_m_epoch_q <= '0;
      rd_index_q   <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sweep_q      <= sweep_d;
      snap_q       <= snap_d;
      rd_epoch_q   <= rd_epoch_d;
      rd_m_epoch_q <= rd_m_epoch_d;
      rd_index_q   <= rd_index_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign rd_epoch   = rd_epoch_q;
  assign rd_m_epoch = rd_m_epoch_q;
  assign rd_index   = rd_index_q;
  assign rd_valid   = rd_valid_q;
  assign count      = count_q;
  assign full       = is_full;

endmodule

// File: tb/tb_lap_bank_ctrl.sv
// Self-checking bench for lap_bank_ctrl: queue-based reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_lap_bank_ctrl;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned EPOCH_W = 18;
  localparam int unsigned MSEC_W  = 10;
  localparam int unsigned DW      = EPOCH_W + MSEC_W;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic                       save = 1'b0;
  logic                       retrieve = 1'b0;
  logic                       clear = 1'b0;
  logic [EPOCH_W-1:0]         epoch = '0;
  logic [MSEC_W-1:0]          m_epoch = '0;
  logic                       busy;
  logic [EPOCH_W-1:0]         rd_epoch;
  logic [MSEC_W-1:0]          rd_m_epoch;
  logic [$clog2(DEPTH)-1:0]   rd_index;
  logic                       rd_valid;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;

  lap_bank_ctrl #(
    .DEPTH   (DEPTH),
    .EPOCH_W (EPOCH_W),
    .MSEC_W  (MSEC_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .save       (save),
    .retrieve   (retrieve),
    .clear      (clear),
    .epoch      (epoch),
    .m_epoch    (m_epoch),
    .busy       (busy),
    .rd_epoch   (rd_epoch),
    .rd_m_epoch (rd_m_epoch),
    .rd_index   (rd_index),
    .rd_valid   (rd_valid),
    .count      (count),
    .full       (full)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: stored laps oldest-first, read position relative to oldest
  logic [DW-1:0]      mq[$];
  int                 m_rd = 0;
  int                 m_busy = 0;
  int                 m_pend = 0;   // 1 = save, 2 = retrieve
  logic [DW-1:0]      m_snap = '0;
  logic [EPOCH_W-1:0] m_re = '0;
  logic [MSEC_W-1:0]  m_rm = '0;
  int                 m_ri = 0;
  logic               m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      mq.delete();
      m_rd = 0; m_busy = 0; m_pend = 0;
      m_re = '0; m_rm = '0; m_ri = 0; m_valid = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if (m_busy == 0) begin
      if (clear) begin
        mq.delete();
        m_rd = 0; m_re = '0; m_rm = '0; m_ri = 0;
        m_busy = DEPTH; m_pend = 0;
      end else if (save) begin
        m_snap = {epoch, m_epoch};
        m_busy = 1; m_pend = 1;
      end else if (retrieve) begin
        m_busy = 1; m_pend = 2;
      end
    end else begin
      m_busy--;
      if (m_busy == 0 && m_pend == 1) begin
        if (mq.size() < DEPTH) mq.push_back(m_snap);
        else begin
`ifdef LAP_BANK_OVERWRITE_EN
          void'(mq.pop_front());
          mq.push_back(m_snap);
          m_rd = (m_rd > 0) ? m_rd - 1 : 0;
`endif
        end
      end else if (m_busy == 0 && m_pend == 2 && mq.size() > 0) begin
        m_re    = mq[m_rd][DW-1:MSEC_W];
        m_rm    = mq[m_rd][MSEC_W-1:0];
        m_ri    = m_rd;
        m_valid = 1'b1;
        m_rd    = (m_rd + 1) % mq.size();
      end
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  // Compare DUT against the model every cycle, away from the active edge
  initial forever begin
    @(negedge clock);
    chk("busy", 32'(busy), 32'(m_busy != 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_epoch", 32'(rd_epoch), 32'(m_re));
    chk("rd_m_epoch", 32'(rd_m_epoch), 32'(m_rm));
    chk("rd_index", 32'(rd_index), 32'(m_ri));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the following negedge with commands dropped
  task automatic cmd(input logic s, input logic r, input logic c,
                     input logic [EPOCH_W-1:0] e, input logic [MSEC_W-1:0] m);
    save = s; retrieve = r; clear = c; epoch = e; m_epoch = m;
    @(negedge clock);
    save = 1'b0; retrieve = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", 32'(m_busy != 0), 32'd0);
  endtask

  task automatic do_save(input logic [EPOCH_W-1:0] e, input logic [MSEC_W-1:0] m);
    cmd(1'b1, 1'b0, 1'b0, e, m);
    @(negedge clock);
  endtask

  task automatic do_retrieve();
    cmd(1'b0, 1'b1, 1'b0, '0, '0);
    @(negedge clock);
  endtask

  task automatic do_clear();
    cmd(1'b0, 1'b0, 1'b1, '0, '0);
    wait_idle();
  endtask

  function automatic logic [EPOCH_W-1:0] t_ep(input int k);
    return {6'(k), 6'(k + 10), 6'(k + 20)};
  endfunction

  initial begin
    logic [EPOCH_W-1:0] e3;
    int n;

    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_epoch", 32'(rd_epoch), 32'd0);

    // Reset then save {1,2,3}.456 and retrieve it
    e3 = {6'd1, 6'd2, 6'd3};
    cmd(1'b1, 1'b0, 1'b0, e3, 10'd456);
    chk("save_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("save_done_busy", 32'(busy), 32'd0);
    chk("save_count", 32'(count), 32'd1);
    do_retrieve();
    chk("r1_epoch", 32'(rd_epoch), 32'd4227);
    chk("r1_msec", 32'(rd_m_epoch), 32'd456);
    chk("r1_index", 32'(rd_index), 32'd0);
    chk("r1_valid", 32'(rd_valid), 32'd1);
    @(negedge clock);
    chk("r1_valid_drop", 32'(rd_valid), 32'd0);

    // Save three, retrieve four
    do_clear();
    for (int k = 0; k < 3; k++) do_save(t_ep(k), 10'(100 + k));
    for (int k = 0; k < 4; k++) begin
      do_retrieve();
      chk("cyc_index", 32'(rd_index), 32'(k % 3));
      chk("cyc_epoch", 32'(rd_epoch), 32'(t_ep(k % 3)));
      chk("cyc_msec", 32'(rd_m_epoch), 32'(100 + (k % 3)));
    end

    // Fill and overflow
    do_clear();
    for (int k = 0; k < 9; k++) do_save(t_ep(k), 10'(100 + k));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      do_retrieve();
      chk("ovf_index", 32'(rd_index), 32'(k));
`ifdef LAP_BANK_OVERWRITE_EN
      chk("ovf_epoch", 32'(rd_epoch), 32'(t_ep(k + 1)));
`else
      chk("ovf_epoch", 32'(rd_epoch), 32'(t_ep(k)));
`endif
    end

    // Simultaneous clear/save/retrieve: only clear runs
    cmd(1'b1, 1'b1, 1'b1, t_ep(40), 10'd999);
    chk("sim_rd_zero", 32'(rd_epoch), 32'd0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("sim_busy_cycles", 32'(n), 32'd8);
    chk("sim_count", 32'(count), 32'd0);

    // Retrieve on empty bank
    cmd(1'b0, 1'b1, 1'b0, '0, '0);
    chk("empty_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("empty_valid", 32'(rd_valid), 32'd0);
    chk("empty_epoch", 32'(rd_epoch), 32'd0);
    chk("empty_busy_end", 32'(busy), 32'd0);

    // Reset during sweep
    do_save(t_ep(5), 10'd55);
    cmd(1'b0, 1'b0, 1'b1, '0, '0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rsw_busy", 32'(busy), 32'd0);
    chk("rsw_count", 32'(count), 32'd0);
    #1 reset = 1'b0;
    @(negedge clock);
    do_save(t_ep(7), 10'd77);
    do_retrieve();
    chk("rsw_index", 32'(rd_index), 32'd0);
    chk("rsw_epoch", 32'(rd_epoch), 32'(t_ep(7)));

    // Randomized phase: commands regardless of busy, rare clears and resets
    for (int i = 0; i < 3000; i++) begin
      save     = ($urandom_range(0, 2) == 0);
      retrieve = ($urandom_range(0, 2) == 0);
      clear    = ($urandom_range(0, 59) == 0);
      epoch    = EPOCH_W'($urandom);
      m_epoch  = MSEC_W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
      @(negedge clock);
    end
    save = 1'b0; retrieve = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
